hba_byte_master: RTL and testbench

- HBA bus master. It sits directly upstream of HBA slave peripherals such as register banks, and drives the shared hba_rwn, hba_abus and hba_dbus.
- It converts a byte-stream command protocol into single-byte or burst register reads and writes. The input stream comes from a UART or SPI receiver; the output stream goes to the matching transmitter.
- Read data and write acknowledgements are returned on a valid/ready byte stream.

---
 rtl/hba_byte_master.sv | 143 ++++++++++++++
 tb/tb_hba_byte_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hba_byte_master.sv
// HBA bus master: turns a byte-stream command protocol into single or burst
// register reads/writes on the HBA bus and returns read data / write acks.
module hba_byte_master #(
  parameter int         DBUS_WIDTH        = 8,
  parameter int         PERIPH_ADDR_WIDTH = 4,
  parameter int         REG_ADDR_WIDTH    = 8,
  parameter int         ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int         TIMEOUT           = 255,
  parameter logic [7:0] ACK_BYTE          = 8'hAC
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  hba_rwn,
  output logic [ADDR_WIDTH-1:0] hba_abus,
  output logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic                  hba_select,
  input  logic                  hba_xferack,
  input  logic [DBUS_WIDTH-1:0] hba_sdbus,
  output logic                  err_timeout
);

  if (DBUS_WIDTH != 8) begin : g_bad_dbus_width
    $error("hba_byte_master: DBUS_WIDTH must be 8 for a byte stream");
  end

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    BUS,
    RESP,
    ACK
  } state_t;

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  state_t                      state, state_nxt;
  logic                        rdy_en;     // holds in_ready low for the cycle after reset
  logic [2:0]                  remain;     // transfers left after the current one
  logic [PERIPH_ADDR_WIDTH-1:0] periph;
  logic [REG_ADDR_WIDTH-1:0]   reg_addr;
  logic [7:0]                  tcnt;
  logic                        in_fire, out_fire;
  logic                        xfer_done, timed_out;

  // The register field wraps on its own; the peripheral field never changes mid-burst.
  assign hba_abus = {periph, reg_addr};
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    hba_select = 1'b0;
    timed_out  = 1'b0;
    xfer_done  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en) state_nxt = ADDR;
      end
      ADDR: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = hba_rwn ? BUS : WDATA;
      end
      WDATA: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUS;
      end
      BUS: begin
        hba_select = 1'b1;
        timed_out  = !hba_xferack && (tcnt == TCNT_LAST);
        xfer_done  = hba_xferack || timed_out;
        if (xfer_done) begin
          if (hba_rwn)          state_nxt = RESP;
          else if (remain == 0) state_nxt = ACK;
          else                  state_nxt = WDATA;
        end
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = (remain == 0) ? IDLE : BUS;
      end
      ACK: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state       <= IDLE;
      rdy_en      <= 1'b0;
      remain      <= '0;
      periph      <= '0;
      reg_addr    <= '0;
      hba_rwn     <= 1'b1;
      hba_dbus    <= '0;
      out_data    <= '0;
      tcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      tcnt   <= (state == BUS) ? tcnt + 8'd1 : 8'd0;
      case (state)
        IDLE: if (in_fire) begin
          hba_rwn <= in_data[7];
          remain  <= in_data[6:4];
          periph  <= PERIPH_ADDR_WIDTH'(in_data[3:0]);
        end
        ADDR:  if (in_fire) reg_addr <= REG_ADDR_WIDTH'(in_data);
        WDATA: if (in_fire) hba_dbus <= in_data;
        BUS: if (xfer_done) begin
          reg_addr <= reg_addr + 1'b1;
          if (timed_out) err_timeout <= 1'b1;
          if (hba_rwn) begin
            // A timed-out read returns zero rather than whatever floats on sdbus.
            out_data <= hba_xferack ? hba_sdbus : 8'h00;
          end else if (remain != 3'd0) begin
            remain <= remain - 3'd1;
          end else begin
            out_data <= ACK_BYTE;
          end
        end
        RESP: if (out_fire && remain != 3'd0) remain <= remain - 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hba_byte_master.sv
// Self-checking bench for hba_byte_master: directed and random commands against
// a transaction-level model, with a behavioural slave and bus monitor.
module tb_hba_byte_master;

  localparam int TIMEOUT = 255;

  logic        hba_clk = 1'b0;
  logic        hba_reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        hba_rwn;
  logic [11:0] hba_abus;
  logic [7:0]  hba_dbus;
  logic        hba_select;
  logic        hba_xferack = 1'b0;
  logic [7:0]  hba_sdbus = 8'h00;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  // slave / monitor controls and records
  int          dly_min = 1, dly_max = 1;
  bit          ack_never = 1'b0, noise_en = 1'b0;
  logic [7:0]  rd_q[$];
  logic [11:0] tr_abus[$];
  logic        tr_rwn[$];
  logic [7:0]  tr_dbus[$];
  int          len_q[$], len_exp_q[$];
  int          sel_cyc = 0, cur_dly = 0;
  bit          prev_sel = 1'b0;
  logic [11:0] st_abus;
  logic        st_rwn;
  logic [7:0]  st_dbus;
  int          bus_unstable = 0, both_high = 0, hold_err = 0, stall_sel = 0;

  hba_byte_master #(.TIMEOUT(TIMEOUT)) dut (
    .hba_clk     (hba_clk),
    .hba_reset   (hba_reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .hba_rwn     (hba_rwn),
    .hba_abus    (hba_abus),
    .hba_dbus    (hba_dbus),
    .hba_select  (hba_select),
    .hba_xferack (hba_xferack),
    .hba_sdbus   (hba_sdbus),
    .err_timeout (err_timeout)
  );

  always #5 hba_clk = ~hba_clk;

  // Behavioural slave: acks after a chosen number of select cycles, junk on sdbus otherwise.
  always @(negedge hba_clk) begin
    if (hba_select === 1'b1) begin
      if (!prev_sel) begin
        sel_cyc = 0;
        cur_dly = ack_never ? 0 : int'($urandom_range(dly_min, dly_max));
        st_abus = hba_abus; st_rwn = hba_rwn; st_dbus = hba_dbus;
        tr_abus.push_back(hba_abus);
        tr_rwn.push_back(hba_rwn);
        tr_dbus.push_back(hba_dbus);
        len_exp_q.push_back(ack_never ? TIMEOUT : cur_dly);
      end
      sel_cyc++;
      if (hba_abus !== st_abus || hba_rwn !== st_rwn || hba_dbus !== st_dbus) bus_unstable++;
      if (!ack_never && sel_cyc == cur_dly) begin
        hba_xferack = 1'b1;
        if (hba_rwn && rd_q.size() > 0) hba_sdbus = rd_q.pop_front();
        else hba_sdbus = 8'($urandom);
      end else begin
        hba_xferack = 1'b0;
        hba_sdbus = 8'($urandom);
      end
    end else begin
      if (prev_sel) len_q.push_back(sel_cyc);
      hba_xferack = noise_en && ($urandom_range(0, 3) == 0);
      hba_sdbus = 8'($urandom);
    end
    if (in_ready === 1'b1 && out_valid === 1'b1) both_high++;
    prev_sel = (hba_select === 1'b1);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_q.delete(); tr_abus.delete(); tr_rwn.delete(); tr_dbus.delete();
    len_q.delete(); len_exp_q.delete();
  endtask

  // Called and returns on a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n = 0;
    in_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) @(negedge hba_clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 2000) begin @(negedge hba_clk); n++; end
    if (in_ready !== 1'b1) check("in_ready_wait", in_ready, 1'b1);
    else @(posedge hba_clk);
    @(negedge hba_clk);
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] d, input int stall);
    int n = 0;
    while (out_valid !== 1'b1 && n < 2000) begin @(negedge hba_clk); n++; end
    check("out_valid_wait", out_valid, 1'b1);
    d = out_data;
    repeat (stall) begin
      @(negedge hba_clk);
      if (out_data !== d || out_valid !== 1'b1) hold_err++;
      if (hba_select !== 1'b0) stall_sel++;
    end
    out_ready = 1'b1;
    @(negedge hba_clk);
    out_ready = 1'b0;
  endtask

  // Model: burst of n transfers at {periph, (r+k) mod 256}; reads echo slave data
  // (zero on timeout), writes end with one 0xAC.
  task automatic run_cmd(input bit rwn, input int n, input logic [3:0] periph,
                         input logic [7:0] r, input logic [63:0] data, input bit rnd,
                         input int gap_max, input int stall, input bit tmo);
    logic [7:0] bytes [8];
    logic [7:0] got;
    logic [7:0] ra;
    clear_mon();
    ack_never = tmo;
    for (int k = 0; k < 8; k++) bytes[k] = rnd ? 8'($urandom) : data[8*k +: 8];
    if (rwn) for (int k = 0; k < n; k++) rd_q.push_back(bytes[k]);
    send_byte({rwn, 3'(n - 1), periph}, gap_max);
    send_byte(r, gap_max);
    if (rwn) begin
      for (int k = 0; k < n; k++) begin
        recv_byte(got, stall);
        check("rd_data", got, tmo ? 8'h00 : bytes[k]);
      end
    end else begin
      for (int k = 0; k < n; k++) send_byte(bytes[k], gap_max);
      recv_byte(got, stall);
      check("ack_byte", got, 8'hAC);
    end
    repeat (2) @(negedge hba_clk);
    check("xfer_count", tr_abus.size(), n);
    check("sel_len_count", len_q.size(), n);
    for (int k = 0; k < n && k < tr_abus.size(); k++) begin
      ra = r + 8'(k);
      check("xfer_abus", tr_abus[k], {periph, ra});
      check("xfer_rwn", tr_rwn[k], rwn);
      if (!rwn) check("xfer_dbus", tr_dbus[k], bytes[k]);
      if (k < len_q.size()) check("sel_len", len_q[k], len_exp_q[k]);
    end
    ack_never = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_select", hba_select, 1'b0);
    check("rst_rwn", hba_rwn, 1'b1);
    check("rst_abus", hba_abus, 12'h000);
    check("rst_dbus", hba_dbus, 8'h00);
    check("rst_err", err_timeout, 1'b0);
  endtask

  initial begin
    int n;
    logic [7:0] b;

    // Reset
    repeat (3) @(negedge hba_clk);
    check_reset_outputs();
    hba_reset = 1'b0;
    @(negedge hba_clk);
    check("idle_in_ready", in_ready, 1'b1);

    // Single write, ack on 2nd select cycle
    dly_min = 2; dly_max = 2;
    run_cmd(1'b0, 1, 4'h3, 8'h10, 64'h5A, 1'b0, 0, 0, 1'b0);

    // Burst read wrapping 0xFF -> 0x00
    dly_min = 1; dly_max = 1;
    run_cmd(1'b1, 3, 4'h2, 8'hFE, 64'h332211, 1'b0, 0, 0, 1'b0);

    // Same burst with 10 cycles of backpressure per byte
    run_cmd(1'b1, 3, 4'h2, 8'hFE, 64'h332211, 1'b0, 0, 10, 1'b0);
    check("bp_hold", hold_err, 0);
    check("bp_no_select", stall_sel, 0);
    check("err_before_timeout", err_timeout, 1'b0);

    // Timeout on a single read
    run_cmd(1'b1, 1, 4'h5, 8'h00, 64'h0, 1'b1, 0, 0, 1'b1);
    check("err_set", err_timeout, 1'b1);

    // 4-byte write with random input gaps
    dly_min = 1; dly_max = 3;
    run_cmd(1'b0, 4, 4'($urandom), 8'($urandom), 64'h0, 1'b1, 6, 0, 1'b0);
    check("err_sticky", err_timeout, 1'b1);

    // Random commands, spurious acks outside BUS
    noise_en = 1'b1;
    dly_min = 1; dly_max = 4;
    for (int i = 0; i < 20; i++) begin
      run_cmd(1'($urandom), int'($urandom_range(1, 8)), 4'($urandom),
              ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom),
              64'h0, 1'b1, 3, int'($urandom_range(0, 3)), 1'b0);
    end
    noise_en = 1'b0;

    // Reset during the bus phase of the 2nd write byte
    clear_mon();
    dly_min = 1; dly_max = 1;
    send_byte(8'h23, 0);
    send_byte(8'h40, 0);
    send_byte(8'hA1, 0);
    n = 0;
    while (!(in_ready === 1'b1 && hba_select === 1'b0) && n < 100) begin
      @(negedge hba_clk); n++;
    end
    check("mid_wdata_ready", in_ready, 1'b1);
    ack_never = 1'b1;
    send_byte(8'hB2, 0);
    repeat (2) @(negedge hba_clk);
    check("mid_select", hba_select, 1'b1);
    hba_reset = 1'b1;
    @(negedge hba_clk);
    check_reset_outputs();
    hba_reset = 1'b0;
    @(negedge hba_clk);
    check("post_rst_ready", in_ready, 1'b1);
    check("post_rst_valid", out_valid, 1'b0);
    ack_never = 1'b0;
    repeat (2) @(negedge hba_clk);
    run_cmd(1'b1, 2, 4'h7, 8'h80, 64'h0, 1'b1, 1, 1, 1'b0);
    check("post_rst_err", err_timeout, 1'b0);
    run_cmd(1'b0, 2, 4'h1, 8'hFF, 64'h0, 1'b1, 1, 1, 1'b0);

    // Whole-run invariants
    check("bus_stable", bus_unstable, 0);
    check("ready_valid_excl", both_high, 0);
    check("out_hold", hold_err, 0);
    check("stall_no_select", stall_sel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
